// File: rtl/pipe_adder_pkg.sv
// ---------------------------------------------------------------------------
// pipe_adder_pkg
//   Shared types and helpers for the pipelined adder/subtractor.
//   - op_e       : operation select carried on the 'sub' input.
//   - num_stages : number of pipeline stages for a given WIDTH/CHUNK split.
// ---------------------------------------------------------------------------
package pipe_adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // One stage per CHUNK-bit slice. A zero chunk is rejected by the top's
  // elaboration checks; returning 1 here keeps the division well defined
  // long enough for that check to report.
  function automatic int num_stages(input int width, input int chunk);
    return (chunk > 0) ? (width / chunk) : 1;
  endfunction

endpackage : pipe_adder_pkg

// File: rtl/pipe_adder_chunk.sv
// ---------------------------------------------------------------------------
// adder_chunk
//   Combinational CHUNK-bit slice adder used once per pipeline stage.
//   Ports:
//     a, b      in  CHUNK  operand slices (b already inverted for subtract)
//     cin       in  1      carry into the slice LSB
//     s         out CHUNK  slice sum
//     cout      out 1      carry out of the slice MSB
//     c_msb_in  out 1      carry into the slice MSB (signed overflow term)
// ---------------------------------------------------------------------------
module adder_chunk
  import pipe_adder_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign s    = full[CHUNK-1:0];
  assign cout = full[CHUNK];

  // The sum bit at the MSB is a ^ b ^ carry_in, so the carry into the MSB
  // falls out of the same XOR. Valid for any CHUNK, including 1.
  assign c_msb_in = a[CHUNK-1] ^ b[CHUNK-1] ^ full[CHUNK-1];

endmodule : adder_chunk

// File: rtl/pipe_adder.sv
// ---------------------------------------------------------------------------
// pipe_adder
//   Pipelined two's-complement adder/subtractor, CHUNK bits per stage, with
//   valid/ready handshaking on both sides. One operation per clock.
//   Ports:
//     clk, rst_n   in   clock (rising edge), async active-low reset
//     in_valid     in   operand set present
//     in_ready     out  operand set can be accepted this cycle
//     a, b         in   WIDTH-bit operands
//     cin          in   carry-in (borrow-in when sub = 1)
//     sub          in   0 = add, 1 = subtract
//     out_valid    out  result present
//     out_ready    in   consumer takes the result
//     s            out  WIDTH-bit result
//     cout         out  raw carry out of the MSB (subtract: 1 = no borrow)
//     ovf          out  signed overflow
//
//   Stage k adds slice k and registers: the result word (slices 0..k valid,
//   upper slices still holding operand A), its carry out, and the not yet
//   consumed effective-B slices shifted down so the next slice is always at
//   the bottom. The whole pipe freezes while the output is stalled.
// ---------------------------------------------------------------------------
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NSTAGES = num_stages(WIDTH, CHUNK);
  // Forwarding registers exist only between stages; keep at least one
  // element so the declaration stays legal when NSTAGES = 1.
  localparam int NFWD    = (NSTAGES > 1) ? (NSTAGES - 1) : 1;

  // -------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // -------------------------------------------------------------------------
  if (CHUNK < 1) begin : g_chk_chunk
    $error("pipe_adder: CHUNK must be at least 1");
  end else if ((WIDTH % CHUNK) != 0) begin : g_chk_div
    $error("pipe_adder: WIDTH must be a multiple of CHUNK");
  end

  // -------------------------------------------------------------------------
  // Operand selection at accept: subtract is a + ~b + !cin
  // -------------------------------------------------------------------------
  op_e              op;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  assign op      = op_e'(sub);
  assign b_eff   = (op == OP_SUB) ? ~b   : b;
  assign cin_eff = (op == OP_SUB) ? ~cin : cin;

  // -------------------------------------------------------------------------
  // Pipeline state
  // -------------------------------------------------------------------------
  logic             vld_q   [NSTAGES];
  logic [WIDTH-1:0] word_q  [NSTAGES];
  logic [WIDTH-1:0] bfw_q   [NFWD];
  logic             carry_q [NFWD];
  logic             msb_c   [NSTAGES];
  logic             cout_q;
  logic             ovf_q;
  logic             stall;

  // Stall depends only on the output side, so in_ready has no path from
  // in_valid.
  assign stall    = vld_q[NSTAGES-1] && !out_ready;
  assign in_ready = !stall;

  assign out_valid = vld_q[NSTAGES-1];
  assign s         = word_q[NSTAGES-1];
  assign cout      = cout_q;
  assign ovf       = ovf_q;

  // Replace slice idx of a word with a freshly computed sum slice.
  function automatic logic [WIDTH-1:0] put_slice(input logic [WIDTH-1:0] w,
                                                 input logic [CHUNK-1:0] sl,
                                                 input int               idx);
    logic [WIDTH-1:0] r;
    r = w;
    r[idx*CHUNK +: CHUNK] = sl;
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // Stages
  // -------------------------------------------------------------------------
  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    localparam int LO = k * CHUNK;

    logic             v_in;
    logic [WIDTH-1:0] w_in;
    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic [CHUNK-1:0] s_sl;
    logic             c_in;
    logic             c_out;

    // Stage 0 is fed straight from the input port; later stages from the
    // previous stage's registers.
    if (k == 0) begin : g_src_in
      assign v_in = in_valid;
      assign w_in = a;
      assign b_sl = b_eff[CHUNK-1:0];
      assign c_in = cin_eff;
    end else begin : g_src_pipe
      assign v_in = vld_q[k-1];
      assign w_in = word_q[k-1];
      assign b_sl = bfw_q[k-1][CHUNK-1:0];
      assign c_in = carry_q[k-1];
    end

    assign a_sl = w_in[LO +: CHUNK];

    adder_chunk #(
      .CHUNK(CHUNK)
    ) u_add (
      .a        (a_sl),
      .b        (b_sl),
      .cin      (c_in),
      .s        (s_sl),
      .cout     (c_out),
      .c_msb_in (msb_c[k])
    );

    if (k < NSTAGES - 1) begin : g_mid
      // NOTE: sequential state is written with <= so every stage samples the
      // previous stage's value from before the edge, not the one just
      // updated; with = the order of blocks would decide the result.
      always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the datapath registers are reset as well as the valid bits,
        // because s/cout/ovf must read 0 straight out of reset.
        if (!rst_n) begin
          vld_q[k]   <= 1'b0;
          word_q[k]  <= '0;
          bfw_q[k]   <= '0;
          carry_q[k] <= 1'b0;
        end else if (!stall) begin
          vld_q[k] <= v_in;
          // Data only moves with a real operation; bubbles leave it alone.
          if (v_in) begin
            word_q[k]  <= put_slice(w_in, s_sl, k);
            carry_q[k] <= c_out;
            if (k == 0) begin
              bfw_q[k] <= b_eff >> CHUNK;
            end else begin
              bfw_q[k] <= bfw_q[k-1] >> CHUNK;
            end
          end
        end
      end
    end else begin : g_last
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q[k]  <= 1'b0;
          word_q[k] <= '0;
          cout_q    <= 1'b0;
          ovf_q     <= 1'b0;
        end else if (!stall) begin
          vld_q[k] <= v_in;
          if (v_in) begin
            word_q[k] <= put_slice(w_in, s_sl, k);
            cout_q    <= c_out;
            // Signed overflow: carry into the MSB differs from carry out.
            ovf_q     <= c_out ^ msb_c[k];
          end
        end
      end
    end
  end : g_stage

endmodule : pipe_adder
